rr_arb4_3: RTL and testbench



---
 rtl/rr_arb4_3.sv | 187 ++++++++++++++++++
 tb/tb_rr_arb4_3.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4_3.sv
// ============================================================================
//  Module   : rr_arb4_3
//  Brief    : Round-robin arbiter and sequencer for a shared 4:1 selector of
//             3-bit values. One requester is granted at a time. The grant is
//             held until done, requester withdrawal, or a hold timeout.
//  Options  : RR_ARB_LOCK_EN - adds a 'lock' input that suppresses the hold
//             timeout while the current grantee keeps requesting.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb4_3 #(
   parameter int unsigned HOLD_MAX = 4   // 1..15, cycles a grant may be held without done
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [2:0] a_in,
   input  logic [2:0] b_in,
   input  logic [2:0] c_in,
   input  logic [2:0] d_in,
   input  logic       done,
`ifdef RR_ARB_LOCK_EN
   input  logic       lock,
`endif
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic [2:0] out,
   output logic       valid,
   output logic       tmo
);

   // Arbiter state: IDLE has no grant, BUSY holds exactly one grant.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Hold count value on which a grant without done is forcibly released.
   localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

   state_t     state_q, state_d;
   logic [3:0] gnt_q,   gnt_d;
   logic [1:0] sel_q,   sel_d;
   logic       valid_q, valid_d;
   logic       tmo_q,   tmo_d;
   logic [1:0] ptr_q,   ptr_d;
   logic [3:0] hold_q,  hold_d;

   // Circular search: first set bit of r starting at index base.
   // Returns {found, index}. Iterating from the far end lets the nearest
   // candidate overwrite the result last.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = base + 2'(k);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   logic [2:0] pick_idle;     // candidate when starting from idle (search from ptr)
   logic [2:0] pick_rel;      // candidate after releasing grantee sel_q (search from sel_q+1)
   logic       cur_req;       // grantee still requesting
   logic       at_max;        // hold count reached its final allowed value
   logic       lock_any;      // lock input asserted (zero without the option)
   logic       lock_hold;     // lock is actively suppressing the timeout
   logic       timeout_rel;   // grant released because its hold time expired
   logic       release_gnt;   // grant ends this cycle for any reason

   // Candidate selection and release qualification for the current grant.
   always_comb begin
      pick_idle   = rr_pick(req, ptr_q);
      pick_rel    = rr_pick(req, sel_q + 2'd1);
      cur_req     = req[sel_q];
      at_max      = (hold_q == HOLD_LAST);
`ifdef RR_ARB_LOCK_EN
      lock_any    = lock;
      lock_hold   = lock & cur_req;
`else
      lock_any    = 1'b0;
      lock_hold   = 1'b0;
`endif
      timeout_rel = at_max & ~done & ~lock_hold;
      release_gnt = done | ~cur_req | timeout_rel;
   end

   // Next-state and registered-output computation for the arbiter.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      tmo_d   = 1'b0;
      ptr_d   = ptr_q;
      hold_d  = hold_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_idle[2]) begin
               state_d = ST_BUSY;
               gnt_d   = 4'b0001 << pick_idle[1:0];
               sel_d   = pick_idle[1:0];
               valid_d = 1'b1;
               hold_d  = 4'd0;
            end
         end

         ST_BUSY: begin
            if (release_gnt) begin
               // done wins over a coincident timeout, and lock masks the pulse.
               tmo_d = at_max & ~done & ~lock_any;
               // The released requester is searched last on the next round.
               ptr_d = sel_q + 2'd1;
               if (pick_rel[2]) begin
                  gnt_d   = 4'b0001 << pick_rel[1:0];
                  sel_d   = pick_rel[1:0];
                  valid_d = 1'b1;
                  hold_d  = 4'd0;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = 4'b0000;
                  sel_d   = 2'b00;
                  valid_d = 1'b0;
                  hold_d  = 4'd0;
               end
            end else if (!(lock_hold && at_max)) begin
               hold_d = hold_q + 4'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            sel_d   = 2'b00;
            valid_d = 1'b0;
            hold_d  = 4'd0;
         end
      endcase
   end

   // State and output registers; reset drops any grant without a tmo pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'b00;
         valid_q <= 1'b0;
         tmo_q   <= 1'b0;
         ptr_q   <= 2'b00;
         hold_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         tmo_q   <= tmo_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   // Shared 4:1 value path, steered by the registered select.
   always_comb begin
      out = 3'b000;
      if (valid_q) begin
         case (sel_q)
            2'd0:    out = a_in;
            2'd1:    out = b_in;
            2'd2:    out = c_in;
            default: out = d_in;
         endcase
      end
   end

   assign gnt   = gnt_q;
   assign sel   = sel_q;
   assign valid = valid_q;
   assign tmo   = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb4_3.sv
// ============================================================================
//  Module   : tb_rr_arb4_3
//  Brief    : Scoreboard testbench for rr_arb4_3. Stimulus is applied on the
//             falling edge, a reference model predicts the registered outputs
//             of the following rising edge, and a monitor compares them.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arb4_3;

   localparam int HOLD_MAX = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = 4'b0000;
   logic [2:0] a_in  = 3'd0;
   logic [2:0] b_in  = 3'd0;
   logic [2:0] c_in  = 3'd0;
   logic [2:0] d_in  = 3'd0;
   logic       done  = 1'b0;
   logic       lock  = 1'b0;

   logic [3:0] gnt;
   logic [1:0] sel;
   logic [2:0] out;
   logic       valid;
   logic       tmo;

   rr_arb4_3 #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .a_in  (a_in),
      .b_in  (b_in),
      .c_in  (c_in),
      .d_in  (d_in),
      .done  (done),
`ifdef RR_ARB_LOCK_EN
      .lock  (lock),
`endif
      .gnt   (gnt),
      .sel   (sel),
      .out   (out),
      .valid (valid),
      .tmo   (tmo)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic       tmo;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: who holds the grant, for how long, and where the
   // next search starts.
   bit m_busy;
   int m_g;
   int m_ptr;
   int m_hold;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int search(input logic [3:0] r, input int base);
      for (int k = 0; k < 4; k++) begin
         if (r[(base + k) % 4]) return (base + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0;
      m_g    = 0;
      m_ptr  = 0;
      m_hold = 0;
   endtask

   // Predict the outputs after the next rising edge from the current inputs.
   task automatic model_step();
      exp_t e;
      bit   tmo_n;
      bit   at;
      bit   lk;
      bit   lock_eff;
      bit   to;
      int   n;
      tmo_n = 0;
`ifdef RR_ARB_LOCK_EN
      lock_eff = lock;
`else
      lock_eff = 0;
`endif
      if (!m_busy) begin
         n = search(req, m_ptr);
         if (n >= 0) begin
            m_busy = 1;
            m_g    = n;
            m_hold = 0;
         end
      end else begin
         at    = (m_hold == HOLD_MAX - 1);
         lk    = lock_eff && req[m_g];
         to    = at && !done && !lk;
         tmo_n = at && !done && !lock_eff;
         if (done || !req[m_g] || to) begin
            m_ptr = (m_g + 1) % 4;
            n = search(req, m_ptr);
            if (n >= 0) begin
               m_g    = n;
               m_hold = 0;
            end else begin
               m_busy = 0;
            end
         end else if (!(lk && at)) begin
            m_hold++;
         end
      end
      e.gnt   = m_busy ? (4'b0001 << m_g) : 4'b0000;
      e.sel   = m_busy ? 2'(m_g) : 2'b00;
      e.valid = m_busy;
      e.tmo   = tmo_n;
      q.push_back(e);
   endtask

   task automatic step(input logic [3:0] r, input logic d, input logic l);
      @(negedge clk);
      req  = r;
      done = d;
      lock = l;
      model_step();
   endtask

   // Monitor: compare every predicted edge result shortly after the edge.
   always @(posedge clk) begin
      exp_t       e;
      logic [2:0] eo;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("gnt",   32'(gnt),   32'(e.gnt));
         chk("sel",   32'(sel),   32'(e.sel));
         chk("valid", 32'(valid), 32'(e.valid));
         chk("tmo",   32'(tmo),   32'(e.tmo));
         case (e.sel)
            2'd0:    eo = a_in;
            2'd1:    eo = b_in;
            2'd2:    eo = c_in;
            default: eo = d_in;
         endcase
         if (!e.valid) eo = 3'b000;
         chk("out", 32'(out), 32'(eo));
      end
   end

   // Pulse reset between clock edges; check the immediate effect, then apply
   // the given request so the first search after reset is exercised.
   task automatic async_reset(input logic [3:0] r);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_gnt",   32'(gnt),   32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_out",   32'(out),   32'h0);
      chk("rst_tmo",   32'(tmo),   32'h0);
      #1 rst_n = 1'b1;
      model_reset();
      req  = r;
      done = 1'b0;
      lock = 1'b0;
      model_step();
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk("init_gnt",   32'(gnt),   32'h0);
      chk("init_sel",   32'(sel),   32'h0);
      chk("init_valid", 32'(valid), 32'h0);
      chk("init_out",   32'(out),   32'h0);
      rst_n = 1'b1;

      // Idle with no requests.
      repeat (5) step(4'b0000, 1'b0, 1'b0);

      // Single requester 2, done on its third grant cycle.
      c_in = 3'b101;
      step(4'b0100, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      step(4'b0100, 1'b1, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      repeat (2) step(4'b0000, 1'b0, 1'b0);

      // Round robin with done every cycle.
      repeat (8) step(4'b1111, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b0);

      // Timeout rotation between requesters 0 and 1.
      async_reset(4'b0011);
      repeat (9) step(4'b0011, 1'b0, 1'b0);
      // done on the timeout cycle suppresses tmo.
      step(4'b0011, 1'b0, 1'b0);
      step(4'b0011, 1'b0, 1'b0);
      step(4'b0011, 1'b1, 1'b0);
      step(4'b0011, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);

      // Withdrawal: grant to 1, then hand over to 3.
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      step(4'b1000, 1'b0, 1'b0);
      step(4'b1000, 1'b0, 1'b0);

      // Reset mid-grant, then all requesting: search restarts from 0.
      async_reset(4'b1111);
      repeat (3) step(4'b1111, 1'b0, 1'b0);

`ifdef RR_ARB_LOCK_EN
      // Lock holds a sole grant past the timeout; dropping it times out.
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      repeat (10) step(4'b0001, 1'b0, 1'b1);
      repeat (3) step(4'b0001, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b1);
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            async_reset(4'($urandom));
         end else begin
            @(negedge clk);
            req  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req | 4'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) req = 4'b0000;
            done = ($urandom_range(0, 3) == 0);
`ifdef RR_ARB_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
`else
            lock = 1'b0;
`endif
            a_in = 3'($urandom);
            b_in = 3'($urandom);
            c_in = 3'($urandom);
            d_in = 3'($urandom);
            model_step();
         end
      end

      repeat (2) @(negedge clk);
      chk("drain", 32'(q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
